// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and counter sizing for clk_div_ratio_ctrl
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WAIT_EDGE = 3'd2,
    APPLY     = 3'd3,
    SETTLE    = 3'd4
  } state_t;

  localparam int DEF_TIMEOUT_CYCLES = 512;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int TMO_CNT_W          = $clog2(DEF_TIMEOUT_CYCLES);
  localparam int SETTLE_CNT_W       = (DEF_SETTLE_CYCLES > 1) ? $clog2(DEF_SETTLE_CYCLES) : 1;

  // Counters hold values 0..n-1, so they need clog2(n) bits, never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// rtl/clk_div_edge_det.sv - falling-edge detector on the fed-back divided clock
module clk_div_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_din;
    end
  end

  assign o_fall = r_prev & ~i_din;

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - glitch-safe ratio/enable update control for the clock divider
// Optional update counter output o_upd_cnt enabled by CLK_DIV_CTRL_UPD_CNT_EN.
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = 8,
  parameter int MIN_RATIO       = 2,
  parameter int RESET_RATIO     = 2,
  parameter int TIMEOUT_CYCLES  = 512,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [DIV_RATIO_WIDTH-1:0] i_req_ratio,
  input  logic                       i_req_en,
  input  logic                       i_div_clk,
  output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
  output logic                       o_clk_en,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_timeout
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  ,
  output logic [7:0]                 o_upd_cnt
`endif
);

  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int SET_W = cnt_width(SETTLE_CYCLES);

  localparam logic [DIV_RATIO_WIDTH-1:0] MIN_R    = DIV_RATIO_WIDTH'(MIN_RATIO);
  localparam logic [DIV_RATIO_WIDTH-1:0] RST_R    = DIV_RATIO_WIDTH'(RESET_RATIO);
  localparam logic [TMO_W-1:0]           TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]           SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                     r_state;
  logic [DIV_RATIO_WIDTH-1:0] r_hold_ratio;
  logic                       r_hold_en;
  logic [TMO_W-1:0]           r_tmo_cnt;
  logic [SET_W-1:0]           r_settle_cnt;

  logic w_fall;
  logic w_xfer;
  logic w_illegal;

  clk_div_edge_det u_edge_det (
    .i_clk  (i_ref_clk),
    .i_rst  (i_rst),
    .i_din  (i_div_clk),
    .o_fall (w_fall)
  );

  assign o_req_ready = (r_state == IDLE) && !i_rst;
  assign w_xfer      = i_req_valid && o_req_ready;
  assign w_illegal   = r_hold_en && (r_hold_ratio < MIN_R);
  assign o_busy      = (r_state != IDLE);

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      o_div_ratio  <= RST_R;
      o_clk_en     <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
      r_hold_ratio <= RST_R;
      r_hold_en    <= 1'b0;
      r_tmo_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_hold_ratio <= i_req_ratio;
            r_hold_en    <= i_req_en;
            r_state      <= CHECK;
          end
        end
        CHECK: begin
          // A stopped divider has no edge to wait for, so it can be updated at once.
          if (w_illegal) begin
            o_err   <= 1'b1;
            r_state <= IDLE;
          end else if (!o_clk_en) begin
            r_state <= APPLY;
          end else begin
            r_tmo_cnt <= '0;
            r_state   <= WAIT_EDGE;
          end
        end
        WAIT_EDGE: begin
          if (w_fall) begin
            r_state <= APPLY;
          end else if (r_tmo_cnt == TMO_LAST) begin
            o_timeout <= 1'b1;
            r_state   <= APPLY;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        APPLY: begin
          o_div_ratio  <= r_hold_ratio;
          o_clk_en     <= r_hold_en;
          r_settle_cnt <= SET_LAST;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt == '0) begin
            o_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  logic [7:0] r_upd_cnt;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_upd_cnt <= 8'd0;
    end else if (r_state == APPLY) begin
      r_upd_cnt <= r_upd_cnt + 8'd1;
    end
  end

  assign o_upd_cnt = r_upd_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb/tb_clk_div_ratio_ctrl.sv - self-checking bench for clk_div_ratio_ctrl
module tb_clk_div_ratio_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_ratio;
  logic         req_en;
  logic         div_clk;
  logic [W-1:0] div_ratio;
  logic         clk_en;
  logic         busy;
  logic         done;
  logic         err;
  logic         timeout;
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  logic [7:0]   upd_cnt;
`endif

  logic gen_on  = 1'b0;
  logic gen_clk = 1'b0;
  logic man_clk = 1'b0;
  int   gen_cnt = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the divider output: toggles every 2 reference cycles.
  always @(negedge clk) begin
    if (gen_cnt == 1) begin
      gen_cnt <= 0;
      gen_clk <= ~gen_clk;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  assign div_clk = gen_on ? gen_clk : man_clk;

  clk_div_ratio_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_ratio (req_ratio),
    .i_req_en    (req_en),
    .i_div_clk   (div_clk),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_timeout   (timeout)
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
    ,
    .o_upd_cnt   (upd_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] ratio;
    logic         en;
    logic         exp_err;
    logic [W-1:0] exp_ratio;
    logic         exp_en;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_req(input logic [W-1:0] ratio, input logic en,
                        output logic saw_done, output logic saw_err);
    req_ratio = ratio;
    req_en    = en;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    saw_done  = 1'b0;
    saw_err   = 1'b0;
    for (int i = 0; i < 2000 && !saw_done && !saw_err; i++) begin
      tick();
      saw_done = done;
      saw_err  = err;
    end
  endtask

  initial begin
    logic sd, se;
    int   first_tmo, first_ratio;

    tbl[0] = '{8'd4,   1'b1, 1'b0, 8'd4,   1'b1};
    tbl[1] = '{8'd1,   1'b1, 1'b1, 8'd4,   1'b1};
    tbl[2] = '{8'd0,   1'b0, 1'b0, 8'd0,   1'b0};
    tbl[3] = '{8'd2,   1'b1, 1'b0, 8'd2,   1'b1};
    tbl[4] = '{8'd255, 1'b1, 1'b0, 8'd255, 1'b1};
    tbl[5] = '{8'd255, 1'b1, 1'b0, 8'd255, 1'b1};
    tbl[6] = '{8'd0,   1'b1, 1'b1, 8'd255, 1'b1};
    tbl[7] = '{8'd9,   1'b0, 1'b0, 8'd9,   1'b0};

    rst = 1'b1; req_valid = 1'b0; req_ratio = '0; req_en = 1'b0;
    tick(); tick();
    check("rst_ready_low", req_ready, 0);
    check("rst_ratio", div_ratio, 2);
    rst = 1'b0;
    tick();
    check("rst_clk_en", clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ready_high", req_ready, 1);

    // Stopped divider: outputs at edge 2, done at edge 6.
    req_ratio = 8'd4; req_en = 1'b1; req_valid = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) req_valid = 1'b0;
      check($sformatf("A_ratio_e%0d", e), div_ratio, (e < 2) ? 4'd2 : 4'd4);
      check($sformatf("A_en_e%0d", e), clk_en, (e < 2) ? 1'b0 : 1'b1);
      check($sformatf("A_done_e%0d", e), done, (e == 6) ? 1'b1 : 1'b0);
    end
    check("A_err", err, 0);
    check("A_ready_end", req_ready, 1);

    // Running divider: fall sampled at edge 6, apply visible after edge 7.
    man_clk = 1'b1;
    tick();
    req_ratio = 8'd7; req_en = 1'b1; req_valid = 1'b1;
    for (int e = 0; e < 8; e++) begin
      man_clk = (e >= 6) ? 1'b0 : 1'b1;
      tick();
      if (e == 0) req_valid = 1'b0;
      check($sformatf("B_ratio_e%0d", e), div_ratio, (e >= 7) ? 8'd7 : 8'd4);
    end
    sd = 1'b0;
    for (int i = 0; i < 20 && !sd; i++) begin
      tick();
      sd = done;
    end
    check("B_done_seen", sd, 1);

    // Illegal request.
    req_ratio = 8'd1; req_en = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("C_ready_check", req_ready, 0);
    check("C_err_e0", err, 0);
    tick();
    check("C_err_e1", err, 1);
    check("C_ready_e1", req_ready, 1);
    check("C_ratio_kept", div_ratio, 7);
    check("C_en_kept", clk_en, 1);
    tick();
    check("C_err_e2", err, 0);
    check("C_ready_e2", req_ready, 1);

    // Timeout: feedback held high.
    man_clk = 1'b1;
    tick();
    check("D_timeout_before", timeout, 0);
    req_ratio = 8'd5; req_en = 1'b1; req_valid = 1'b1;
    first_tmo = -1; first_ratio = -1;
    for (int e = 0; e < 2000; e++) begin
      tick();
      if (e == 0) req_valid = 1'b0;
      if (first_tmo < 0 && timeout) first_tmo = e;
      if (div_ratio == 8'd5) begin
        first_ratio = e;
        break;
      end
    end
    check("D_timeout_edge", first_tmo, 513);
    check("D_apply_edge", first_ratio, 514);
    for (int i = 0; i < 10; i++) tick();
    check("D_timeout_sticky", timeout, 1);
    check("D_idle_after", busy, 0);

    // Reset while waiting for an edge.
    req_ratio = 8'd9; req_en = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("E_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    check("E_ratio", div_ratio, 2);
    check("E_en", clk_en, 0);
    check("E_busy", busy, 0);
    check("E_timeout_clr", timeout, 0);
    check("E_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("E_ratio_lost", div_ratio, 2);
    check("E_ready", req_ready, 1);

    // Table-driven requests against a free-running feedback clock.
    gen_on = 1'b1;
    for (int v = 0; v < 8; v++) begin
      do_req(tbl[v].ratio, tbl[v].en, sd, se);
      check($sformatf("T%0d_err", v), se, tbl[v].exp_err);
      check($sformatf("T%0d_done", v), sd, !tbl[v].exp_err);
      check($sformatf("T%0d_ratio", v), div_ratio, tbl[v].exp_ratio);
      check($sformatf("T%0d_en", v), clk_en, tbl[v].exp_en);
    end

`ifdef CLK_DIV_CTRL_UPD_CNT_EN
    gen_on = 1'b0; man_clk = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("U_reset", upd_cnt, 0);
    for (int n = 0; n < 257; n++) do_req(8'd3, 1'b0, sd, se);
    check("U_wrap", upd_cnt, 1);
    do_req(8'd0, 1'b1, sd, se);
    check("U_illegal_err", se, 1);
    check("U_illegal_nocnt", upd_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
